// File: rtl/fx3_stream_ctrl_pkg.sv
// Shared types and constants for the FX3 slave-FIFO streaming controller.
package fx3_stream_ctrl_pkg;
    localparam int unsigned DATA_WIDTH       = 10;
    localparam int unsigned USB_WIDTH        = 16;
    localparam int unsigned PAD_WIDTH        = USB_WIDTH - DATA_WIDTH;
    localparam int unsigned DEF_READ_LATENCY = 1;
    localparam int unsigned SKID_DEPTH       = DEF_READ_LATENCY + 2;

    typedef enum logic [1:0] {StIdle, StStream, StRelease} state_t;

    // Room for every read that can be in flight plus one word held against a stalled FX3.
    function automatic int unsigned skid_depth(input int unsigned read_latency);
        return read_latency + 2;
    endfunction
endpackage

// File: rtl/fx3_stream_ctrl_if.sv
// Buffer-read and GPIF slave-FIFO signals seen by the streaming controller.
interface fx3_stream_ctrl_if;
    import fx3_stream_ctrl_pkg::*;

    logic                  data_available;
    logic [DATA_WIDTH-1:0] buffer_data;
    logic                  is_reading;
    logic                  fx3_ready;
    logic [USB_WIDTH-1:0]  usb_data;
    logic                  usb_write;

    modport master (
        input  data_available, buffer_data, fx3_ready,
        output is_reading, usb_data, usb_write
    );

    modport slave (
        output data_available, buffer_data, fx3_ready,
        input  is_reading, usb_data, usb_write
    );
endinterface

// File: rtl/fx3_stream_ctrl_skid.sv
// Small synchronous FIFO absorbing buffer reads still in flight when FX3 stalls.
module fx3_stream_ctrl_skid #(
    parameter int unsigned    DEPTH = 3,
    parameter int unsigned    WIDTH = 16,
    localparam int unsigned   CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/fx3_stream_ctrl.sv
// Drains one ping-pong buffer block per dataAvailable and streams it to the FX3 GPIF slave FIFO,
// with read flow control against a skid buffer and an optional counter test pattern.
module fx3_stream_ctrl
    import fx3_stream_ctrl_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS  = 8192,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic              i_read_clock,
    input  logic              i_reset,
    input  logic              i_capture_enable,
    input  logic              i_test_mode,
    fx3_stream_ctrl_if.master io_bus,
    output logic              o_block_done,
    output logic              o_busy
);
    localparam int unsigned DEPTH  = skid_depth(READ_LATENCY);
    localparam int unsigned CNT_W  = $clog2(BLOCK_WORDS + 1);
    localparam int unsigned SCNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W  = $clog2(DEPTH + READ_LATENCY + 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_reads_left;
    logic [CNT_W-1:0]        r_writes_left;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [DATA_WIDTH-1:0]   r_pattern;

    logic                    w_start;
    logic                    w_is_reading;
    logic                    w_ret_valid;
    logic                    w_skid_empty;
    logic                    w_usb_write;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic [OCC_W-1:0]        w_in_flight;
    logic [SCNT_W-1:0]       w_skid_count;
    logic [USB_WIDTH-1:0]    w_ret_word;
    logic [USB_WIDTH-1:0]    w_skid_head;

    always_ff @(posedge i_read_clock or posedge i_reset) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // RELEASE waits for the buffer flag to drop so a drained block is never read twice.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_capture_enable && io_bus.data_available) w_state_next = StStream;
            StStream:  if (r_writes_left == '0) w_state_next = StRelease;
            StRelease: if (!io_bus.data_available) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_is_reading = 1'b0;
        o_block_done = 1'b0;
        o_busy       = 1'b1;
        unique case (r_state)
            StIdle: o_busy = 1'b0;
            StStream: begin
                w_is_reading = (r_reads_left != '0) &&
                               ((OCC_W'(w_skid_count) + w_in_flight) < OCC_W'(DEPTH));
                o_block_done = (r_writes_left == '0);
            end
            default: ;
        endcase
    end

    assign w_start = (r_state == StIdle) && (w_state_next == StStream);

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_in_flight = w_in_flight + OCC_W'(r_rd_pipe[i]);
        end
    end

    always_ff @(posedge i_read_clock or posedge i_reset) begin
        if (i_reset) begin
            r_reads_left  <= '0;
            r_writes_left <= '0;
        end else if (w_start) begin
            r_reads_left  <= CNT_W'(BLOCK_WORDS);
            r_writes_left <= CNT_W'(BLOCK_WORDS);
        end else begin
            if (w_is_reading) r_reads_left  <= r_reads_left - CNT_W'(1);
            if (w_accept)     r_writes_left <= r_writes_left - CNT_W'(1);
        end
    end

    // Pattern advances per word entering the output path; order is preserved, so it tracks accepts.
    always_ff @(posedge i_read_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_pipe <= '0;
            r_pattern <= '0;
        end else begin
            r_rd_pipe[0] <= w_is_reading;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            if (w_ret_valid) r_pattern <= r_pattern + DATA_WIDTH'(1);
        end
    end

    assign w_ret_valid = r_rd_pipe[READ_LATENCY-1];
    assign w_ret_word  = {{PAD_WIDTH{1'b0}}, (i_test_mode ? r_pattern : io_bus.buffer_data)};

    // Returning data bypasses an empty skid so the first write follows the read by READ_LATENCY.
    assign w_usb_write = !w_skid_empty || w_ret_valid;
    assign w_accept    = w_usb_write && io_bus.fx3_ready;
    assign w_pop       = !w_skid_empty && io_bus.fx3_ready;
    assign w_push      = w_ret_valid && !(w_skid_empty && io_bus.fx3_ready);

    fx3_stream_ctrl_skid #(
        .DEPTH (DEPTH),
        .WIDTH (USB_WIDTH)
    ) u_skid (
        .i_clk   (i_read_clock),
        .i_rst   (i_reset),
        .i_push  (w_push),
        .i_data  (w_ret_word),
        .i_pop   (w_pop),
        .o_data  (w_skid_head),
        .o_count (w_skid_count),
        .o_empty (w_skid_empty)
    );

    assign io_bus.is_reading = w_is_reading;
    assign io_bus.usb_write  = w_usb_write;
    assign io_bus.usb_data   = !w_usb_write ? '0 : (w_skid_empty ? w_ret_word : w_skid_head);
endmodule

// File: tb/tb_fx3_stream_ctrl.sv
// Self-checking bench for fx3_stream_ctrl: a buffer model feeds blocks and a word-order model
// predicts every accepted GPIF word.
module tb_fx3_stream_ctrl;
    import fx3_stream_ctrl_pkg::*;

    localparam int unsigned BW = 8192;
    localparam int unsigned RL = 1;

    logic clk;
    logic rst;
    logic cap;
    logic tmode;
    logic block_done;
    logic busy;

    fx3_stream_ctrl_if u_bus ();

    fx3_stream_ctrl #(
        .BLOCK_WORDS  (BW),
        .READ_LATENCY (RL)
    ) u_dut (
        .i_read_clock     (clk),
        .i_reset          (rst),
        .i_capture_enable (cap),
        .i_test_mode      (tmode),
        .io_bus           (u_bus.master),
        .o_block_done     (block_done),
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    logic [DATA_WIDTH-1:0] blk [BW];
    int rd_idx, blk_acc, total_acc, done_cnt, run_len, max_run, cyc, first_rd, first_wr;
    int ready_mode, phase;
    logic                 prev_hold;
    logic [USB_WIDTH-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0: u_bus.fx3_ready = 1'b1;
            1: begin
                phase = (phase + 1) % 5;
                u_bus.fx3_ready = (phase >= 3);
            end
            default: u_bus.fx3_ready = ($urandom_range(3, 0) != 0);
        endcase
    endtask

    // One clock: observe at the falling edge, then update the buffer model just after the rise.
    task automatic step();
        logic rd, acc;
        logic [USB_WIDTH-1:0] exp_w;
        @(negedge clk);
        cyc++;
        rd  = u_bus.is_reading;
        acc = u_bus.usb_write && u_bus.fx3_ready;
        if (prev_hold) begin
            check("hold_write", u_bus.usb_write, 1);
            check("hold_data", u_bus.usb_data, prev_data);
        end
        if (rd && first_rd < 0) first_rd = cyc;
        if (u_bus.usb_write) begin
            if (first_wr < 0) first_wr = cyc;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (block_done) begin
            done_cnt++;
            check("done_after_last", blk_acc, BW);
        end
        if (acc) begin
            if (blk_acc >= BW) begin
                check("word_overrun", blk_acc, BW - 1);
            end else begin
                exp_w = tmode ? {{PAD_WIDTH{1'b0}}, DATA_WIDTH'(total_acc % 1024)}
                              : {{PAD_WIDTH{1'b0}}, blk[blk_acc]};
                check("usb_data", u_bus.usb_data, exp_w);
            end
            blk_acc++;
            total_acc++;
        end
        prev_hold = u_bus.usb_write && !u_bus.fx3_ready;
        prev_data = u_bus.usb_data;
        @(posedge clk);
        #1;
        if (rd) begin
            if (rd_idx < BW) u_bus.buffer_data = blk[rd_idx];
            rd_idx++;
        end
        drive_ready();
    endtask

    task automatic start_block(input int random_data);
        for (int i = 0; i < BW; i++) begin
            blk[i] = random_data ? DATA_WIDTH'($urandom) : DATA_WIDTH'(i % 1024);
        end
        rd_idx   = 0;
        blk_acc  = 0;
        done_cnt = 0;
        first_rd = -1;
        first_wr = -1;
        run_len  = 0;
        max_run  = 0;
    endtask

    task automatic run_until(input int stop_at, input int budget);
        for (int i = 0; i < budget && done_cnt == 0 && blk_acc < stop_at; i++) step();
    endtask

    // Block totals, then hold dataAvailable high in RELEASE before letting it drop.
    task automatic finish_block(input int hold_cycles);
        check("block_done_cnt", done_cnt, 1);
        check("accepts", blk_acc, BW);
        check("reads", rd_idx, BW);
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            check("release_busy", busy, 1);
            check("release_no_read", u_bus.is_reading, 0);
        end
        u_bus.data_available = 1'b0;
        step();
        step();
        check("back_idle", busy, 0);
        check("reads_after", rd_idx, BW);
        check("single_done", done_cnt, 1);
    endtask

    initial begin
        rst = 1'b1;
        cap = 1'b0;
        tmode = 1'b0;
        u_bus.data_available = 1'b0;
        u_bus.buffer_data = '0;
        u_bus.fx3_ready = 1'b0;
        total_acc = 0;
        cyc = 0;
        phase = 0;
        ready_mode = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_is_reading", u_bus.is_reading, 0);
        check("rst_usb_write", u_bus.usb_write, 0);
        check("rst_usb_data", u_bus.usb_data, 0);
        check("rst_block_done", block_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Capture disabled: a ready block must be ignored.
        start_block(0);
        u_bus.data_available = 1'b1;
        repeat (5) step();
        check("disabled_no_read", rd_idx, 0);
        check("disabled_busy", busy, 0);

        // Full-rate block with 0..8191 mod 1024, then 20 cycles in RELEASE.
        cap = 1'b1;
        ready_mode = 0;
        u_bus.fx3_ready = 1'b1;
        run_until(BW + 1, BW + 50);
        check("t1_back_to_back", max_run, BW);
        check("t1_latency", first_wr - first_rd, RL);
        finish_block(20);

        // FX3 ready 3 low / 2 high.
        start_block(1);
        ready_mode = 1;
        phase = 0;
        drive_ready();
        u_bus.data_available = 1'b1;
        run_until(BW + 1, 3 * BW);
        finish_block(2);

        // Test pattern over two blocks with random stalls.
        tmode = 1'b1;
        ready_mode = 2;
        for (int b = 0; b < 2; b++) begin
            start_block(1);
            u_bus.data_available = 1'b1;
            run_until(BW + 1, 3 * BW);
            finish_block(2);
        end
        tmode = 1'b0;

        // Reset mid-burst at word 4000, then a full block from scratch.
        start_block(1);
        ready_mode = 0;
        u_bus.fx3_ready = 1'b1;
        u_bus.data_available = 1'b1;
        run_until(4000, BW);
        check("t5_at_4000", blk_acc, 4000);
        rst = 1'b1;
        #1;
        check("t5_is_reading", u_bus.is_reading, 0);
        check("t5_usb_write", u_bus.usb_write, 0);
        check("t5_usb_data", u_bus.usb_data, 0);
        check("t5_block_done", block_done, 0);
        check("t5_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        total_acc = 0;
        prev_hold = 1'b0;
        start_block(1);
        run_until(BW + 1, BW + 50);
        finish_block(2);

        // captureEnable dropped at word 100: block completes, nothing new starts.
        start_block(1);
        ready_mode = 2;
        u_bus.data_available = 1'b1;
        run_until(100, 3 * BW);
        cap = 1'b0;
        run_until(BW + 1, 3 * BW);
        finish_block(2);
        u_bus.data_available = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            check("t6_stays_idle", busy, 0);
        end
        check("t6_no_reads", rd_idx, BW);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
